// File: rtl/fetch_stage.sv
// Purpose    : instruction fetch front end. Owns the PC, issues one fetch at a time to a
//              variable-latency, non-abortable instruction memory and queues up to 2 words.
// Latency    : a fetched word is visible at the queue head 1 cycle after its imem_rdy cycle.
// Backpressure: id_stall holds the head. No new fetch is issued unless the returned word is
//              guaranteed a free slot, so the queue never overflows.
// Ports      : clk/rst (sync, active-high); imem_req/imem_addr/imem_rdy/imem_data memory
//              port; if_valid/if_inst/if_pc_plus2 queue head to decode; id_stall, redirect,
//              redirect_pc, halt from decode; err sticky protocol/alignment flag.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic        if_valid,
    output logic [15:0] if_inst,
    output logic [15:0] if_pc_plus2,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        err
);

    // S_HALT_DRAIN: halt arrived while a fetch was outstanding. That fetch must
    // still complete on the bus before the stage goes quiet.
    typedef enum logic [2:0] {
        S_RUN,
        S_WAIT,
        S_DRAIN,
        S_HALT_DRAIN,
        S_HALTED
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] r_drain_addr;
    logic [15:0] w_drain_addr_nxt;
    logic [1:0]  r_count;
    logic [15:0] r_q_inst [2];
    logic [15:0] r_q_pc   [2];
    logic        r_err;

    logic        w_pop;
    logic [1:0]  w_cnt_after_pop;
    logic        w_req;
    logic [15:0] w_addr;
    logic        w_push;
    logic        w_flush;
    logic        w_err_set;

    assign w_pop           = (r_count != 2'd0) & ~id_stall & ~redirect & ~halt;
    assign w_cnt_after_pop = r_count - {1'b0, w_pop};

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drain_addr_nxt = r_drain_addr;
        w_req            = 1'b0;
        w_addr           = r_pc;
        w_push           = 1'b0;
        w_flush          = 1'b0;
        case (r_state)
            S_RUN: begin
                // Issue only if the word can land in a free slot after this cycle's pop.
                w_req = (w_cnt_after_pop <= 2'd1) & ~redirect & ~halt;
                if (halt) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_HALTED;
                end else if (redirect) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = redirect_pc;
                end else if (w_req && imem_rdy) begin
                    w_push   = 1'b1;
                    w_pc_nxt = r_pc + 16'd2;
                end else if (w_req) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // The memory cannot abort, so the request is held regardless of redirect/halt.
                w_req = 1'b1;
                if (halt) begin
                    w_flush = 1'b1;
                    if (imem_rdy) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_drain_addr_nxt = r_pc;
                        w_state_nxt      = S_HALT_DRAIN;
                    end
                end else if (redirect) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = redirect_pc;
                    if (imem_rdy) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        // The PC moves to the target, so the in-flight address is kept aside.
                        w_drain_addr_nxt = r_pc;
                        w_state_nxt      = S_DRAIN;
                    end
                end else if (imem_rdy) begin
                    w_push      = 1'b1;
                    w_pc_nxt    = r_pc + 16'd2;
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
                if (halt) begin
                    w_flush     = 1'b1;
                    w_state_nxt = imem_rdy ? S_HALTED : S_HALT_DRAIN;
                end else begin
                    if (redirect) begin
                        w_flush  = 1'b1;
                        w_pc_nxt = redirect_pc;
                    end
                    if (imem_rdy) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_HALT_DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
                if (imem_rdy) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign w_err_set = (redirect & redirect_pc[0]) | (imem_rdy & ~w_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_count      <= 2'd0;
            r_q_inst[0]  <= 16'h0000;
            r_q_inst[1]  <= 16'h0000;
            r_q_pc[0]    <= 16'h0000;
            r_q_pc[1]    <= 16'h0000;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
            if (w_flush) begin
                r_count <= 2'd0;
            end else begin
                if (w_pop) begin
                    r_q_inst[0] <= r_q_inst[1];
                    r_q_pc[0]   <= r_q_pc[1];
                end
                // Push lands in the first slot free after the pop; a later assignment
                // to slot 0 overrides the shift above when the queue empties.
                if (w_push) begin
                    if (w_cnt_after_pop == 2'd0) begin
                        r_q_inst[0] <= imem_data;
                        r_q_pc[0]   <= r_pc;
                    end else begin
                        r_q_inst[1] <= imem_data;
                        r_q_pc[1]   <= r_pc;
                    end
                end
                r_count <= w_cnt_after_pop + {1'b0, w_push};
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign imem_req    = w_req & ~rst;
    assign imem_addr   = w_addr;
    assign if_valid    = ~rst & (r_count != 2'd0);
    assign if_inst     = if_valid ? r_q_inst[0] : 16'h0000;
    assign if_pc_plus2 = if_valid ? (r_q_pc[0] + 16'd2) : 16'h0000;
    assign err         = r_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose    : self-checking bench for fetch_stage with a latency-programmable memory model.
// Latency    : memory answers on the mem_lat-th cycle of a held request.
// Backpressure: decode stall/redirect/halt driven per cycle by the scenario tasks.
module tb_fetch_stage;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        if_valid;
    logic [15:0] if_inst;
    logic [15:0] if_pc_plus2;
    logic        id_stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    int mem_lat   = 1;
    int mem_cnt   = 0;
    bit rand_lat  = 1'b0;
    bit force_rdy = 1'b0;

    logic        s_req, s_rdy, s_valid, s_err;
    logic [15:0] s_addr, s_inst, s_pc2;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc_plus2(if_pc_plus2),
        .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .err(err)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
    endfunction

    // One clock cycle: apply decode-side inputs, let the memory model answer the
    // current request, sample every output, then clock.
    task automatic step(input logic s, input logic r, input logic [15:0] rp, input logic h);
        id_stall    = s;
        redirect    = r;
        redirect_pc = rp;
        halt        = h;
        #1;
        if (force_rdy || (imem_req && (mem_cnt + 1 >= mem_lat))) begin
            imem_rdy  = 1'b1;
            imem_data = mem_word(imem_addr);
        end else begin
            imem_rdy  = 1'b0;
            imem_data = 16'h0000;
        end
        #1;
        s_req   = imem_req;
        s_rdy   = imem_rdy;
        s_addr  = imem_addr;
        s_valid = if_valid;
        s_inst  = if_inst;
        s_pc2   = if_pc_plus2;
        s_err   = err;
        @(posedge clk);
        if (rst) begin
            mem_cnt = 0;
        end else if (s_req && s_rdy) begin
            mem_cnt = 0;
            if (rand_lat) mem_lat = $urandom_range(1, 4);
        end else if (s_req) begin
            mem_cnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 16'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mem_lat = 1;
        rst = 1'b1;
        step(1'b0, 1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", s_req); end
        n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", s_valid); end
        n_vec++; if (s_inst !== 16'h0) begin n_err++; $display("FAIL reset_inst: got %h expected 0000", s_inst); end
        n_vec++; if (s_pc2 !== 16'h0) begin n_err++; $display("FAIL reset_pc2: got %h expected 0000", s_pc2); end
        step(1'b0, 1'b0, 16'h0, 1'b0);
        n_vec++; if (s_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", s_err); end
        n_vec++; if (s_req !== 1'b1 || s_addr !== RESET_PC)
            begin n_err++; $display("FAIL reset_first_fetch: got req=%b addr=%h expected req=1 addr=%h", s_req, s_addr, RESET_PC); end
    endtask

    task automatic test_zero_latency();
        mem_lat = 1;
        do_reset();
        step(1'b0, 1'b0, 16'h0, 1'b0);
        n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL zl_first_valid: got %b expected 0", s_valid); end
        for (int k = 1; k <= 4; k++) begin
            logic [15:0] e;
            e = 16'(2 * k);
            step(1'b0, 1'b0, 16'h0, 1'b0);
            n_vec++;
            if (s_valid !== 1'b1 || s_pc2 !== e || s_inst !== mem_word(e - 16'd2)) begin
                n_err++;
                $display("FAIL zl_seq[%0d]: got v=%b pc2=%h inst=%h expected v=1 pc2=%h inst=%h",
                         k, s_valid, s_pc2, s_inst, e, mem_word(e - 16'd2));
            end
        end
    endtask

    task automatic test_latency3();
        mem_lat = 3;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            logic [15:0] ea;
            logic        ev;
            ea = 16'(2 * (k / 3));
            ev = (k > 0) && (k % 3 == 0);
            step(1'b0, 1'b0, 16'h0, 1'b0);
            n_vec++;
            if (s_req !== 1'b1 || s_addr !== ea) begin
                n_err++;
                $display("FAIL lat3_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", k, s_req, s_addr, ea);
            end
            n_vec++;
            if (s_valid !== ev || (ev && s_pc2 !== ea)) begin
                n_err++;
                $display("FAIL lat3_valid[%0d]: got v=%b pc2=%h expected v=%b pc2=%h", k, s_valid, s_pc2, ev, ea);
            end
        end
        mem_lat = 1;
    endtask

    task automatic test_stall();
        mem_lat = 1;
        do_reset();
        step(1'b0, 1'b0, 16'h0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            n_vec++;
            if (s_valid !== 1'b1 || s_pc2 !== 16'h0002) begin
                n_err++;
                $display("FAIL stall_head[%0d]: got v=%b pc2=%h expected v=1 pc2=0002", k, s_valid, s_pc2);
            end
            if (k >= 2) begin
                n_vec++;
                if (s_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d]: got %b expected 0", k, s_req); end
            end
        end
        for (int k = 0; k < 5; k++) begin
            logic [15:0] e;
            e = 16'(2 + 2 * k);
            step(1'b0, 1'b0, 16'h0, 1'b0);
            n_vec++;
            if (s_valid !== 1'b1 || s_pc2 !== e || s_inst !== mem_word(e - 16'd2)) begin
                n_err++;
                $display("FAIL stall_release[%0d]: got v=%b pc2=%h inst=%h expected v=1 pc2=%h inst=%h",
                         k, s_valid, s_pc2, s_inst, e, mem_word(e - 16'd2));
            end
        end
    endtask

    task automatic test_redirect_drain();
        mem_lat = 3;
        do_reset();
        step(1'b0, 1'b1, 16'h0010, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h0040, 1'b0);
        n_vec++; if (s_req !== 1'b1 || s_addr !== 16'h0010 || s_rdy !== 1'b0)
            begin n_err++; $display("FAIL rd_outstanding: got req=%b addr=%h rdy=%b expected 1 0010 0", s_req, s_addr, s_rdy); end
        step(1'b0, 1'b0, 16'h0, 1'b0);
        n_vec++; if (s_req !== 1'b1 || s_addr !== 16'h0010 || s_valid !== 1'b0)
            begin n_err++; $display("FAIL rd_drain: got req=%b addr=%h v=%b expected 1 0010 0", s_req, s_addr, s_valid); end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            n_vec++;
            if (s_req !== 1'b1 || s_addr !== 16'h0040 || s_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rd_target[%0d]: got req=%b addr=%h v=%b expected 1 0040 0", k, s_req, s_addr, s_valid);
            end
        end
        step(1'b0, 1'b0, 16'h0, 1'b0);
        n_vec++; if (s_valid !== 1'b1 || s_pc2 !== 16'h0042 || s_inst !== mem_word(16'h0040))
            begin n_err++; $display("FAIL rd_first: got v=%b pc2=%h inst=%h expected 1 0042 %h", s_valid, s_pc2, s_inst, mem_word(16'h0040)); end
        mem_lat = 1;
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        do_reset();
        step(1'b0, 1'b1, 16'hFFFC, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            logic [15:0] f;
            f = 16'hFFFC + 16'(2 * k);
            step(1'b0, 1'b0, 16'h0, 1'b0);
            n_vec++;
            if (s_valid !== 1'b1 || s_pc2 !== f + 16'd2 || s_inst !== mem_word(f)) begin
                n_err++;
                $display("FAIL wrap[%0d]: got v=%b pc2=%h inst=%h expected 1 %h %h", k, s_valid, s_pc2, s_inst, f + 16'd2, mem_word(f));
            end
        end
    endtask

    task automatic test_halt();
        mem_lat = 1;
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            n_vec++;
            if (s_req !== 1'b0 || s_valid !== 1'b0) begin
                n_err++;
                $display("FAIL halt_quiet[%0d]: got req=%b v=%b expected 0 0", k, s_req, s_valid);
            end
        end
        do_reset();
        step(1'b0, 1'b0, 16'h0, 1'b0);
        n_vec++; if (s_req !== 1'b1 || s_addr !== RESET_PC)
            begin n_err++; $display("FAIL halt_restart: got req=%b addr=%h expected 1 %h", s_req, s_addr, RESET_PC); end
        step(1'b0, 1'b0, 16'h0, 1'b0);
        n_vec++; if (s_valid !== 1'b1 || s_pc2 !== RESET_PC + 16'd2)
            begin n_err++; $display("FAIL halt_restart_head: got v=%b pc2=%h expected 1 %h", s_valid, s_pc2, RESET_PC + 16'd2); end
        // Halt while a 3-cycle fetch is in flight: the fetch must still finish on the bus.
        mem_lat = 3;
        do_reset();
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        n_vec++; if (s_req !== 1'b1 || s_addr !== RESET_PC || s_valid !== 1'b0)
            begin n_err++; $display("FAIL halt_drain: got req=%b addr=%h v=%b expected 1 %h 0", s_req, s_addr, s_valid, RESET_PC); end
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            n_vec++;
            if (s_req !== 1'b0 || s_valid !== 1'b0) begin
                n_err++;
                $display("FAIL halt_drain_quiet[%0d]: got req=%b v=%b expected 0 0", k, s_req, s_valid);
            end
        end
        mem_lat = 1;
    endtask

    task automatic test_err();
        mem_lat = 1;
        do_reset();
        step(1'b0, 1'b0, 16'h0, 1'b0);
        n_vec++; if (s_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b expected 0", s_err); end
        step(1'b0, 1'b1, 16'h0041, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            n_vec++;
            if (s_err !== 1'b1) begin n_err++; $display("FAIL err_odd_sticky[%0d]: got %b expected 1", k, s_err); end
        end
        do_reset();
        step(1'b0, 1'b0, 16'h0, 1'b0);
        n_vec++; if (s_err !== 1'b0) begin n_err++; $display("FAIL err_after_rst: got %b expected 0", s_err); end
        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        force_rdy = 1'b1;
        step(1'b0, 1'b0, 16'h0, 1'b0);
        force_rdy = 1'b0;
        n_vec++; if (s_req !== 1'b0 || s_err !== 1'b0)
            begin n_err++; $display("FAIL err_stray_setup: got req=%b err=%b expected 0 0", s_req, s_err); end
        step(1'b0, 1'b0, 16'h0, 1'b0);
        n_vec++; if (s_err !== 1'b1) begin n_err++; $display("FAIL err_stray_rdy: got %b expected 1", s_err); end
    endtask

    // Stream-level reference: decode must see consecutive addresses from the last
    // reset/redirect target, each with the memory word at that address.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] prev_addr;
        logic [15:0] rp;
        logic        prev_hold, halted, s, r, h, do_rst;
        int          pops;
        exp_pc    = RESET_PC;
        prev_addr = 16'h0;
        prev_hold = 1'b0;
        halted    = 1'b0;
        pops      = 0;
        rand_lat  = 1'b1;
        mem_lat   = 2;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            do_rst = halted ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 299) == 0);
            s      = ($urandom_range(0, 9) < 3);
            r      = ($urandom_range(0, 19) == 0);
            h      = ($urandom_range(0, 399) == 0);
            rp     = 16'($urandom) & 16'hFFFE;
            rst    = do_rst;
            step(s, r, rp, h);
            rst    = 1'b0;
            if (do_rst) begin
                exp_pc    = RESET_PC;
                halted    = 1'b0;
                prev_hold = 1'b0;
                continue;
            end
            if (prev_hold) begin
                n_vec++;
                if (s_req !== 1'b1 || s_addr !== prev_addr) begin
                    n_err++;
                    $display("FAIL rnd_hold[%0d]: got req=%b addr=%h expected 1 %h", c, s_req, s_addr, prev_addr);
                end
            end else if (halted) begin
                n_vec++;
                if (s_req !== 1'b0) begin n_err++; $display("FAIL rnd_halt_req[%0d]: got %b expected 0", c, s_req); end
            end
            n_vec++;
            if (s_err !== 1'b0) begin n_err++; $display("FAIL rnd_err[%0d]: got %b expected 0", c, s_err); end
            if (halted) begin
                n_vec++;
                if (s_valid !== 1'b0) begin n_err++; $display("FAIL rnd_halt_valid[%0d]: got %b expected 0", c, s_valid); end
            end else if (s_valid && !s && !r && !h) begin
                n_vec++;
                if (s_pc2 !== exp_pc + 16'd2 || s_inst !== mem_word(exp_pc)) begin
                    n_err++;
                    $display("FAIL rnd_stream[%0d]: got pc2=%h inst=%h expected %h %h", c, s_pc2, s_inst, exp_pc + 16'd2, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 16'd2;
                pops++;
            end
            prev_hold = s_req && !s_rdy;
            prev_addr = s_addr;
            if (!halted && h) halted = 1'b1;
            else if (!halted && r) exp_pc = rp;
        end
        rand_lat = 1'b0;
        mem_lat  = 1;
        n_vec++;
        if (pops < 300) begin n_err++; $display("FAIL rnd_progress: got %0d pops expected at least 300", pops); end
    endtask

    initial begin
        rst         = 1'b1;
        id_stall    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        halt        = 1'b0;
        imem_rdy    = 1'b0;
        imem_data   = 16'h0;
        test_reset();
        test_zero_latency();
        test_latency3();
        test_stall();
        test_redirect_drain();
        test_wrap();
        test_halt();
        test_err();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch front end for the processor. It owns the PC, issues one-at-a-time requests to a variable-latency, non-abortable instruction memory, and buffers returned instructions in a 2-entry queue for decode. It also handles decode stalls, branch/jump redirects (flush plus discard of any in-flight fetch) and HALT. It replaces the bare PC register and combinational instruction-memory read in front of the decode/control stage.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high with imem_addr stable until imem_rdy.
- imem_addr  out  16  fetch address (current PC).
- imem_rdy  in  1  memory done; imem_data valid this cycle; only legal while imem_req=1.
- imem_data  in  16  fetched instruction word.
- if_valid  out  1  queue head holds a valid instruction.
- if_inst  out  16  queue head instruction.
- if_pc_plus2  out  16  queue head fetch address + 2.
- id_stall  in  1  decode cannot accept head this cycle.
- redirect  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  16  target PC.
- halt  in  1  decode consumed HALT; stop fetching.
- err  out  1  sticky protocol/alignment error.

## Operation
- Reset (rst=1 at edge): pc=RESET_PC, queue count=0, state=RUN, err=0; during reset cycle imem_req=0, if_valid=0, if_inst=0, if_pc_plus2=0.
- pop = if_valid & ~id_stall & ~redirect & ~halt. Head advances on pop.
- States: RUN (no request outstanding), WAIT (request outstanding), DRAIN (outstanding request to be discarded), HALTED.
- RUN: imem_req = (count - pop) <= 1 & ~redirect & ~halt; imem_addr=pc. If req & imem_rdy: push {imem_data, pc}, pc+=2, stay RUN. If req & ~imem_rdy: go WAIT (pc held).
- WAIT: imem_req=1, addr held. On imem_rdy: push, pc+=2, go RUN. Room is guaranteed by the issue condition; count never exceeds 2.
- DRAIN: imem_req=1, addr = old pc (latched separately); on imem_rdy data dropped, go RUN; pc already equals redirect target.
- redirect (any non-HALTED state): queue cleared, pc=redirect_pc, no push that cycle. From WAIT with imem_rdy=0 -> DRAIN; from WAIT with imem_rdy=1 -> RUN (data dropped); from DRAIN -> stays DRAIN until rdy; from RUN -> RUN.
- halt: queue cleared; if request outstanding, drain it (rdy data dropped), then HALTED. In HALTED imem_req=0, if_valid=0 until rst. halt and redirect in the same cycle: halt wins.
- PC arithmetic: 16-bit, wraps 16'hFFFE -> 16'h0000 silently.
- err set (sticky until rst) when: redirect with redirect_pc[0]=1; or imem_rdy=1 while imem_req=0.

## Timing
- Zero-latency memory (rdy in same cycle as req) with no stalls: one instruction per cycle; instruction fetched at edge N is visible on if_valid/if_inst after edge N.
- Fetch-to-decode latency: 1 cycle after the imem_rdy cycle.
- Redirect penalty: target request issued the cycle after redirect (RUN) or the cycle after the dropped rdy (DRAIN).
- imem_addr/imem_req are combinational from registered state and the current-cycle redirect/halt/id_stall only; no path from imem_data.
- Mid-operation reset overrides everything, including an outstanding request; the bench memory model must also reset.

## Test plan
- Zero-latency memory, id_stall=0: after reset, if_pc_plus2 sequence 2,4,6,8 on consecutive cycles, if_valid=1 from the second cycle.
- 3-cycle memory latency: imem_addr held at 0x0004 for 3 cycles with imem_req=1; one instruction every 3 cycles, if_valid gaps in between.
- id_stall=1 for 5 cycles with zero-latency memory: queue fills to 2, imem_req drops, head stays 0x0002 plus-2 value; on release, order is preserved and nothing is lost or duplicated.
- redirect to 0x0040 while a 3-cycle fetch of 0x0010 is outstanding: enter DRAIN, returned word dropped, next imem_addr=0x0040, first if_pc_plus2=0x0042.
- halt asserted: if_valid=0 next cycle, imem_req stays 0 for 20 cycles; rst restarts at RESET_PC.
- redirect_pc=0x0041 -> err=1 and stays 1 until rst; imem_rdy pulsed with imem_req=0 -> err=1.
